// File: rtl/uart_pkg.sv
// Shared UART definitions.
//  - Default oversample ratio and divisor widths.
//  - Divisor record {div_int, div_frac} at the default widths, for software-facing code and benches.
//  - calc_def_div(): clocks per oversample tick for a given clock, baud and oversample ratio,
//    rounded up.
package uart_pkg;

  localparam int unsigned UART_OVERSAMPLE = 16;
  localparam int unsigned UART_DIV_W      = 16;
  localparam int unsigned UART_FRAC_W     = 4;

  typedef struct packed {
    logic [UART_DIV_W-1:0]  div_int;
    logic [UART_FRAC_W-1:0] div_frac;
  } uart_div_t;

  function automatic int unsigned calc_def_div(input int unsigned clk_freq,
                                               input int unsigned baud,
                                               input int unsigned os);
    int unsigned den;
    den = baud * os;
    return (clk_freq + den - 1) / den;
  endfunction

endpackage

// File: rtl/uart_frac_acc.sv
// Fractional-divisor accumulator for uart_baud_gen.
// Ports:
//  clk_i      system clock
//  rst_ni     synchronous reset, active-low
//  clr_i      clear the accumulator on the next edge (re-phase)
//  step_i     a period ends on this edge: accumulate frac_i
//  frac_i     fractional divisor, units of 1/2^FRAC_W clock
//  stretch_o  carry of acc + frac_i; the period now running is one clock longer
module uart_frac_acc
  import uart_pkg::*;
#(
  parameter int unsigned FRAC_W = UART_FRAC_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              step_i,
  input  logic [FRAC_W-1:0] frac_i,
  output logic              stretch_o
);

  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, frac_i};
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (step_i) begin
      acc_d = sum[FRAC_W-1:0];
    end
  end

  assign stretch_o = sum[FRAC_W];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/uart_baud_gen.sv
// Baud / oversample tick generator for the UART TX and RX paths.
// Optional feature: define UART_BAUD_FRAC_EN to enable the fractional divisor (div_frac_i);
// otherwise div_frac_i is ignored and every period is exactly the integer divisor.
// Ports:
//  clk_i          system clock, rising edge
//  rst_ni         synchronous reset, active-low
//  en_i           1 = run, 0 = hold counters, no ticks
//  div_int_i      integer clocks per os_tick (values < 2 act as 2)
//  div_frac_i     fractional clocks per os_tick, 1/2^FRAC_W units
//  div_load_i     strobe: capture the divisor into the shadow
//  restart_i      strobe: re-phase all counters to zero
//  div_pending_o  shadow divisor captured but not yet active
//  os_tick_o      oversample strobe, one clock wide
//  bit_tick_o     bit strobe, on every OVERSAMPLE-th os_tick
//  baud_clk_o     square wave, one bit period, high for the second half of the bit
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = 50000000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = UART_OVERSAMPLE,
  parameter int unsigned DIV_W      = UART_DIV_W,
  parameter int unsigned FRAC_W     = UART_FRAC_W
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [DIV_W-1:0]  div_int_i,
  input  logic [FRAC_W-1:0] div_frac_i,
  input  logic              div_load_i,
  input  logic              restart_i,
  output logic              div_pending_o,
  output logic              os_tick_o,
  output logic              bit_tick_o,
  output logic              baud_clk_o
);

  localparam int unsigned CntW   = DIV_W + 1;
  localparam int unsigned OsW    = $clog2(OVERSAMPLE);
  localparam int unsigned DefDiv = calc_def_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);

  localparam logic [OsW-1:0]   OsLast = OsW'(OVERSAMPLE - 1);
  localparam logic [OsW-1:0]   OsHalf = OsW'(OVERSAMPLE / 2 - 1);
  localparam logic [DIV_W-1:0] DivMin = DIV_W'(2);
  localparam logic [DIV_W-1:0] DivDef = DIV_W'(DefDiv);

  function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] d);
    return (d < DivMin) ? DivMin : d;
  endfunction

  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [OsW-1:0]    os_cnt_q, os_cnt_d;
  logic [DIV_W-1:0]  act_int_q, act_int_d;
  logic [FRAC_W-1:0] act_frac_q, act_frac_d;
  logic [DIV_W-1:0]  sh_int_q, sh_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d;
  logic              pending_q, pending_d;
  logic              os_tick_q, os_tick_d;
  logic              bit_tick_q, bit_tick_d;
  logic              baud_q, baud_d;

  logic              stretch;
  logic [CntW-1:0]   period_m1;
  logic              wrap;

  // act_int_q is never below 2, so period_m1 is never negative.
  assign period_m1 = {1'b0, act_int_q} + {{DIV_W{1'b0}}, stretch} - CntW'(1);
  // >= rather than == so a divisor made active while disabled can shrink below cnt_q safely.
  assign wrap      = en_i && (cnt_q >= period_m1);

`ifdef UART_BAUD_FRAC_EN
  uart_frac_acc #(
    .FRAC_W(FRAC_W)
  ) u_frac_acc (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .clr_i    (restart_i),
    .step_i   (wrap && !restart_i),
    .frac_i   (act_frac_q),
    .stretch_o(stretch)
  );
`else
  assign stretch = 1'b0;
  logic unused_frac;
  assign unused_frac = ^act_frac_q;
`endif

  always_comb begin
    cnt_d      = cnt_q;
    os_cnt_d   = os_cnt_q;
    act_int_d  = act_int_q;
    act_frac_d = act_frac_q;
    sh_int_d   = sh_int_q;
    sh_frac_d  = sh_frac_q;
    pending_d  = pending_q;
    os_tick_d  = 1'b0;
    bit_tick_d = 1'b0;
    baud_d     = baud_q;

    if (restart_i) begin
      cnt_d    = '0;
      os_cnt_d = '0;
      baud_d   = 1'b0;
      // A load alongside restart bypasses the shadow and takes effect at once.
      if (div_load_i) begin
        sh_int_d   = div_int_i;
        sh_frac_d  = div_frac_i;
        act_int_d  = clamp_div(div_int_i);
        act_frac_d = div_frac_i;
        pending_d  = 1'b0;
      end else if (pending_q) begin
        act_int_d  = clamp_div(sh_int_q);
        act_frac_d = sh_frac_q;
        pending_d  = 1'b0;
      end
    end else if (en_i) begin
      if (wrap) begin
        cnt_d      = '0;
        os_tick_d  = 1'b1;
        bit_tick_d = (os_cnt_q == OsLast);
        os_cnt_d   = (os_cnt_q == OsLast) ? '0 : os_cnt_q + OsW'(1);
        if (os_cnt_q == OsHalf) begin
          baud_d = 1'b1;
        end
        if (os_cnt_q == OsLast) begin
          baud_d = 1'b0;
        end
        // Divisor switches only on a period boundary so no tick is glitched.
        if (pending_q) begin
          act_int_d  = clamp_div(sh_int_q);
          act_frac_d = sh_frac_q;
          pending_d  = 1'b0;
        end
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
      // A load on the wrap edge waits for the following boundary.
      if (div_load_i) begin
        sh_int_d  = div_int_i;
        sh_frac_d = div_frac_i;
        pending_d = 1'b1;
      end
    end else begin
      // Disabled: no boundary to wait for, so the divisor applies straight away.
      if (div_load_i) begin
        sh_int_d   = div_int_i;
        sh_frac_d  = div_frac_i;
        act_int_d  = clamp_div(div_int_i);
        act_frac_d = div_frac_i;
        pending_d  = 1'b0;
      end else if (pending_q) begin
        act_int_d  = clamp_div(sh_int_q);
        act_frac_d = sh_frac_q;
        pending_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q      <= '0;
      os_cnt_q   <= '0;
      act_int_q  <= clamp_div(DivDef);
      act_frac_q <= '0;
      sh_int_q   <= DivDef;
      sh_frac_q  <= '0;
      pending_q  <= 1'b0;
      os_tick_q  <= 1'b0;
      bit_tick_q <= 1'b0;
      baud_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      os_cnt_q   <= os_cnt_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      pending_q  <= pending_d;
      os_tick_q  <= os_tick_d;
      bit_tick_q <= bit_tick_d;
      baud_q     <= baud_d;
    end
  end

  assign div_pending_o = pending_q;
  assign os_tick_o     = os_tick_q;
  assign bit_tick_o    = bit_tick_q;
  assign baud_clk_o    = baud_q;

endmodule

// File: tb/tb_uart_baud_gen.sv
// Bench for uart_baud_gen: expected tick times come from plain arithmetic on the divisor
// (tick k after a re-phase lands at r + k*div + floor(k*frac/16), shifted by any disabled
// span), queued by the stimulus and checked by an independent negedge monitor.
module tb_uart_baud_gen;
  import uart_pkg::*;

  localparam int unsigned ClkFreq  = 1600000;
  localparam int unsigned BaudRate = 10000;
  localparam int unsigned Os       = 16;
  localparam int unsigned DivW     = 16;
  localparam int unsigned FracW    = 4;
  localparam longint      NoGap    = 64'd1 << 60;
`ifdef UART_BAUD_FRAC_EN
  localparam bit FracEn = 1'b1;
`else
  localparam bit FracEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n, en, div_load, restart;
  uart_div_t        div_cfg;
  logic [DivW-1:0]  div_int;
  logic [FracW-1:0] div_frac;
  logic             div_pending, os_tick, bit_tick, baud_clk;

  assign div_int  = div_cfg.div_int;
  assign div_frac = div_cfg.div_frac;

  uart_baud_gen #(
    .CLK_FREQ  (ClkFreq),
    .BAUD_RATE (BaudRate),
    .OVERSAMPLE(Os),
    .DIV_W     (DivW),
    .FRAC_W    (FracW)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .en_i         (en),
    .div_int_i    (div_int),
    .div_frac_i   (div_frac),
    .div_load_i   (div_load),
    .restart_i    (restart),
    .div_pending_o(div_pending),
    .os_tick_o    (os_tick),
    .bit_tick_o   (bit_tick),
    .baud_clk_o   (baud_clk)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; a value seen at negedge belongs to edge cyc.
  longint cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    longint cyc;
    bit     is_tick;  // 0: re-phase point (restart/reset edge), no tick, baud_clk low
    bit     bit_t;
    bit     baud;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   passes = 0;
  bit   exp_baud = 1'b0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rephase(input longint c);
    exp_t e;
    e.cyc = c; e.is_tick = 1'b0; e.bit_t = 1'b0; e.baud = 1'b0;
    exp_q.push_back(e);
  endtask

  // Ticks j0+1 .. j0+n after re-phase (or period boundary) r.
  task automatic expect_run(input longint r, input int j0, input int n, input int dv,
                            input int fr, input longint gs, input int gl,
                            output longint t_last);
    int   p;
    int   f;
    exp_t e;
    p      = (dv < 2) ? 2 : dv;
    f      = FracEn ? fr : 0;
    t_last = r;
    for (int k = 1; k <= n; k++) begin
      int     j;
      longint t;
      j = j0 + k;
      t = r + longint'(k) * p + (longint'(k) * f) / (1 << FracW);
      if (t >= gs) t += gl;
      e.cyc = t; e.is_tick = 1'b1;
      e.bit_t = (j % Os) == 0;
      e.baud  = (j % Os) >= (Os / 2);
      exp_q.push_back(e);
      t_last = t;
    end
  endtask

  // Steps until edge 'stop', holding en low for edges gs .. gs+gl-1.
  task automatic run_until(input longint stop, input longint gs, input int gl);
    while (cyc < stop) begin
      en = !((cyc + 1 >= gs) && (cyc + 1 < gs + gl));
      step();
    end
    en = 1'b1;
  endtask

  // restart + div_load together: new divisor active immediately, returns the re-phase edge.
  task automatic start_seg(input int dv, input int fr, output longint r);
    restart = 1'b1;
    div_load = 1'b1;
    div_cfg.div_int  = DivW'(dv);
    div_cfg.div_frac = FracW'(fr);
    r = cyc + 1;
    push_rephase(r);
    step();
    restart  = 1'b0;
    div_load = 1'b0;
  endtask

  task automatic drain(input string name);
    chk(name, exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: consumes the expectation queue as the DUT presents ticks.
  always @(negedge clk) begin
    exp_t e;
    while (exp_q.size() != 0 && !exp_q[0].is_tick && exp_q[0].cyc <= cyc) begin
      e = exp_q.pop_front();
      chk("rephase_no_tick", os_tick, 0);
      exp_baud = 1'b0;
    end
    if (os_tick) begin
      if (exp_q.size() != 0 && exp_q[0].is_tick) begin
        e = exp_q.pop_front();
        chk("os_tick_time", cyc, e.cyc);
        chk("bit_tick", bit_tick, e.bit_t);
        exp_baud = e.baud;
      end else begin
        chk("os_tick_unexpected", os_tick, 0);
      end
    end else begin
      chk("bit_tick_idle", bit_tick, 0);
      if (exp_q.size() != 0 && exp_q[0].is_tick && exp_q[0].cyc <= cyc) begin
        e = exp_q.pop_front();
        chk("os_tick_missing", os_tick, 1);
        exp_baud = e.baud;
      end
    end
    chk("baud_clk", baud_clk, exp_baud);
  end

  initial begin
    longint r, r2, t, t1, gs;
    int     pend, dv, fr, n, gl;

    rst_n = 1'b0; en = 1'b1; div_load = 1'b0; restart = 1'b0; div_cfg = '0;

    // 1: reset 3 clocks, then free-run at the default divisor of 10.
    step();
    chk("rst_os_tick", os_tick, 0);
    chk("rst_bit_tick", bit_tick, 0);
    chk("rst_baud_clk", baud_clk, 0);
    chk("rst_div_pending", div_pending, 0);
    step();
    step();
    rst_n = 1'b1;
    r = cyc;
    expect_run(r, 0, 32, 10, 0, NoGap, 0, t);
    run_until(t + 1, NoGap, 0);
    drain("q_default");

    // 2: load div 4 with cnt reaching 3; current period still ends at 10.
    start_seg(10, 0, r);
    expect_run(r, 0, 1, 10, 0, NoGap, 0, t1);
    expect_run(t1, 1, 20, 4, 0, NoGap, 0, t);
    step();
    step();
    div_load = 1'b1;
    div_cfg.div_int  = DivW'(4);
    div_cfg.div_frac = '0;
    step();
    div_load = 1'b0;
    pend = 0;
    for (int k = 0; k < 10; k++) begin
      pend += int'(div_pending);
      step();
    end
    chk("div_pending_len", pend, 7);
    run_until(t + 1, NoGap, 0);
    drain("q_load");

    // 3: div 4 + 8/16 (periods 4,5 with the fractional build).
    start_seg(4, 8, r);
    expect_run(r, 0, 16, 4, 8, NoGap, 0, t);
    chk("frac_span", t - r, FracEn ? 72 : 64);
    run_until(t + 1, NoGap, 0);
    drain("q_frac");

    // 4: restart with os_cnt = 9 (baud_clk high).
    start_seg(10, 0, r);
    expect_run(r, 0, 9, 10, 0, NoGap, 0, t);
    run_until(t + 2, NoGap, 0);
    chk("baud_before_restart", baud_clk, 1);
    restart = 1'b1;
    r2 = cyc + 1;
    push_rephase(r2);
    expect_run(r2, 0, 16, 10, 0, NoGap, 0, t);
    step();
    restart = 1'b0;
    run_until(t + 1, NoGap, 0);
    drain("q_restart");

    // 5: 25 disabled clocks mid-period.
    start_seg(10, 0, r);
    gs = r + 25;
    expect_run(r, 0, 8, 10, 0, gs, 25, t);
    run_until(t + 1, gs, 25);
    drain("q_enable");

    // 6: clamp to 2, then reset mid-run with a load pending.
    start_seg(1, 0, r);
    expect_run(r, 0, 15, 1, 0, NoGap, 0, t);
    run_until(t, NoGap, 0);
    div_load = 1'b1;
    div_cfg.div_int = DivW'(7);
    step();
    div_load = 1'b0;
    chk("pending_before_reset", div_pending, 1);
    rst_n = 1'b0;
    push_rephase(cyc + 1);
    push_rephase(cyc + 2);
    step();
    chk("midrst_os_tick", os_tick, 0);
    chk("midrst_bit_tick", bit_tick, 0);
    chk("midrst_baud_clk", baud_clk, 0);
    chk("midrst_div_pending", div_pending, 0);
    step();
    rst_n = 1'b1;
    r = cyc;
    expect_run(r, 0, 16, 10, 0, NoGap, 0, t);
    run_until(t + 1, NoGap, 0);
    drain("q_reset");

    // Random divisors, fractions and enable gaps.
    for (int s = 0; s < 6; s++) begin
      dv = int'($urandom_range(1, 12));
      fr = int'($urandom_range(0, 15));
      n  = int'($urandom_range(12, 36));
      gl = int'($urandom_range(0, 30));
      start_seg(dv, fr, r);
      gs = r + longint'($urandom_range(2, 80));
      expect_run(r, 0, n, dv, fr, gs, gl, t);
      run_until(t + 1, gs, gl);
      drain("q_random");
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
